// File: rtl/psc_trigger_pkg.sv
// Shared types and defaults for the PSC frame-aligned trigger scheduler.
package psc_trigger_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b001,
        ST_WAIT   = 3'b110,
        ST_ACTIVE = 3'b011
    } trig_state_e;

    localparam int unsigned DEF_NUM_CH       = 4;
    localparam int unsigned DEF_FRAME_LEN    = 10;
    localparam int unsigned DEF_CNT_W        = 4;
    localparam int unsigned DEF_HOLD_FRAMES  = 1;
    localparam int unsigned DEF_PEND_W       = 3;
    localparam int unsigned DEF_BACK_TO_BACK = 0;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        if (value > 1) begin
            for (int unsigned v = value - 1; v != 0; v = v >> 1) begin
                w++;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/psc_trigger_ch.sv
// One trigger channel: request FSM, hold-frame counter, saturating pending count and sticky overflow.
module psc_trigger_ch
    import psc_trigger_pkg::*;
#(
    parameter int unsigned HOLD_FRAMES  = DEF_HOLD_FRAMES,
    parameter int unsigned PEND_W       = DEF_PEND_W,
    parameter int unsigned BACK_TO_BACK = DEF_BACK_TO_BACK
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ch_en,
    input  logic              trigger_pulse,
    input  logic              frame_tick,
    input  logic              ovf_clr,
    output logic              is_trigger,
    output logic [PEND_W-1:0] pending_cnt,
    output logic              overflow
);

    localparam int unsigned       HOLD_W    = (clog2(HOLD_FRAMES) > 0) ? clog2(HOLD_FRAMES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;

    trig_state_e       state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              is_trigger_q, is_trigger_d;
    logic              req_inc, req_dec;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        pend_d  = pend_q;
        ovf_d   = ovf_clr ? 1'b0 : ovf_q;
        req_inc = 1'b0;
        req_dec = 1'b0;

        if (!ch_en) begin
            state_d = ST_IDLE;
            hold_d  = '0;
            pend_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trigger_pulse) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    req_inc = trigger_pulse;
                    if (frame_tick) begin
                        state_d = ST_ACTIVE;
                        hold_d  = '0;
                    end
                end
                ST_ACTIVE: begin
                    req_inc = trigger_pulse;
                    if (frame_tick) begin
                        if (hold_q == HOLD_LAST) begin
                            // A strobe landing on the exit cycle counts as queued even with pend_q==0.
                            if (pend_q != '0 || trigger_pulse) begin
                                req_dec = 1'b1;
                                hold_d  = '0;
                                state_d = (BACK_TO_BACK != 0) ? ST_ACTIVE : ST_WAIT;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            hold_d = hold_q + HOLD_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                    pend_d  = '0;
                end
            endcase

            if (req_inc && !req_dec) begin
                if (pend_q == PEND_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    pend_d = pend_q + PEND_W'(1);
                end
            end else if (req_dec && !req_inc) begin
                pend_d = pend_q - PEND_W'(1);
            end
        end

        is_trigger_d = (state_d == ST_ACTIVE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            pend_q       <= '0;
            ovf_q        <= 1'b0;
            is_trigger_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            pend_q       <= pend_d;
            ovf_q        <= ovf_d;
            is_trigger_q <= is_trigger_d;
        end
    end

    assign is_trigger  = is_trigger_q;
    assign pending_cnt = pend_q;
    assign overflow    = ovf_q;

endmodule

// File: rtl/psc_trigger_sched.sv
// Frame-aligned multi-channel trigger scheduler: shared TX frame counter plus NUM_CH independent channels.
module psc_trigger_sched
    import psc_trigger_pkg::*;
#(
    parameter int unsigned NUM_CH       = DEF_NUM_CH,
    parameter int unsigned FRAME_LEN    = DEF_FRAME_LEN,
    parameter int unsigned CNT_W        = DEF_CNT_W,
    parameter int unsigned HOLD_FRAMES  = DEF_HOLD_FRAMES,
    parameter int unsigned PEND_W       = DEF_PEND_W,
    parameter int unsigned BACK_TO_BACK = DEF_BACK_TO_BACK
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic [NUM_CH-1:0]        trigger_pulse,
    input  logic                     ovf_clr,
    output logic [CNT_W-1:0]         tx_counter,
    output logic                     frame_tick,
    output logic [NUM_CH-1:0]        is_trigger,
    output logic [NUM_CH*PEND_W-1:0] pending_cnt,
    output logic [NUM_CH-1:0]        overflow
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    logic [CNT_W-1:0] tx_counter_q, tx_counter_d;
    logic             tick;

    assign tick = (tx_counter_q == CNT_LAST);

    always_comb begin
        tx_counter_d = tick ? '0 : tx_counter_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_counter_q <= '0;
        end else begin
            tx_counter_q <= tx_counter_d;
        end
    end

    assign tx_counter = tx_counter_q;
    assign frame_tick = tick;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        psc_trigger_ch #(
            .HOLD_FRAMES  (HOLD_FRAMES),
            .PEND_W       (PEND_W),
            .BACK_TO_BACK (BACK_TO_BACK)
        ) u_ch (
            .clk           (clk),
            .reset_n       (reset_n),
            .ch_en         (ch_en[ch]),
            .trigger_pulse (trigger_pulse[ch]),
            .frame_tick    (tick),
            .ovf_clr       (ovf_clr),
            .is_trigger    (is_trigger[ch]),
            .pending_cnt   (pending_cnt[ch*PEND_W +: PEND_W]),
            .overflow      (overflow[ch])
        );
    end

endmodule

// File: tb/tb_psc_trigger_sched.sv
// Scoreboard bench: three parameterisations share one stimulus stream and are checked against a frame-level model.
module tb_psc_trigger_sched;

    localparam int NDUT = 3;
    localparam int NCH  = 4;
    localparam int FL   = 10;

    // Per-DUT configuration: A defaults, B hold 3 / back-to-back / 2-bit pending, C hold 3 / gap frame.
    int P_HOLD [NDUT] = '{1, 3, 3};
    int P_B2B  [NDUT] = '{0, 1, 0};
    int P_PMAX [NDUT] = '{7, 3, 7};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_n;
    logic [NCH-1:0]   ch_en, trigger_pulse;
    logic             ovf_clr;

    logic [3:0]  cnt_a, cnt_b, cnt_c;
    logic        tick_a, tick_b, tick_c;
    logic [3:0]  trig_a, trig_b, trig_c;
    logic [11:0] pend_a, pend_c;
    logic [7:0]  pend_b;
    logic [3:0]  ovf_a, ovf_b, ovf_c;

    psc_trigger_sched u_dut_a (
        .clk(clk), .reset_n(reset_n), .ch_en(ch_en), .trigger_pulse(trigger_pulse), .ovf_clr(ovf_clr),
        .tx_counter(cnt_a), .frame_tick(tick_a), .is_trigger(trig_a), .pending_cnt(pend_a), .overflow(ovf_a)
    );

    psc_trigger_sched #(.HOLD_FRAMES(3), .BACK_TO_BACK(1), .PEND_W(2)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .ch_en(ch_en), .trigger_pulse(trigger_pulse), .ovf_clr(ovf_clr),
        .tx_counter(cnt_b), .frame_tick(tick_b), .is_trigger(trig_b), .pending_cnt(pend_b), .overflow(ovf_b)
    );

    psc_trigger_sched #(.HOLD_FRAMES(3), .BACK_TO_BACK(0), .PEND_W(3)) u_dut_c (
        .clk(clk), .reset_n(reset_n), .ch_en(ch_en), .trigger_pulse(trigger_pulse), .ovf_clr(ovf_clr),
        .tx_counter(cnt_c), .frame_tick(tick_c), .is_trigger(trig_c), .pending_cnt(pend_c), .overflow(ovf_c)
    );

    typedef struct packed {
        logic [3:0]        cnt;
        logic              tick;
        logic [2:0][3:0]   trig;
        logic [2:0][11:0]  pend;
        logic [2:0][3:0]   ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Model state: a channel is "waiting" for the next boundary, or has m_left window frames remaining.
    int m_cnt;
    int m_wait [NDUT][NCH];
    int m_left [NDUT][NCH];
    int m_pend [NDUT][NCH];
    bit m_ovf  [NDUT][NCH];

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        for (int d = 0; d < NDUT; d++)
            for (int ch = 0; ch < NCH; ch++) begin
                m_wait[d][ch] = 0;
                m_left[d][ch] = 0;
                m_pend[d][ch] = 0;
                m_ovf[d][ch]  = 1'b0;
            end
    endtask

    task automatic chan_step(input int d, input int ch, input bit en, input bit tp, input bit clr, input bit tick);
        int avail;
        int consume;
        if (clr) m_ovf[d][ch] = 1'b0;
        if (!en) begin
            m_wait[d][ch] = 0;
            m_left[d][ch] = 0;
            m_pend[d][ch] = 0;
            return;
        end
        if (m_wait[d][ch] == 0 && m_left[d][ch] == 0) begin
            if (tp) m_wait[d][ch] = 1;
            return;
        end
        avail   = m_pend[d][ch] + (tp ? 1 : 0);
        consume = 0;
        if (tick) begin
            if (m_left[d][ch] > 0) begin
                m_left[d][ch]--;
                if (m_left[d][ch] == 0 && avail > 0) begin
                    consume = 1;
                    if (P_B2B[d] != 0) m_left[d][ch] = P_HOLD[d];
                    else               m_wait[d][ch] = 1;
                end
            end else begin
                m_wait[d][ch] = 0;
                m_left[d][ch] = P_HOLD[d];
            end
        end
        avail = avail - consume;
        if (avail > P_PMAX[d]) begin
            avail = P_PMAX[d];
            m_ovf[d][ch] = 1'b1;
        end
        m_pend[d][ch] = avail;
    endtask

    task automatic model_step(input logic rn, input logic [NCH-1:0] en, input logic [NCH-1:0] tp, input logic clr);
        bit   tick;
        exp_t e;
        tick = (m_cnt == FL - 1);
        if (!rn) begin
            model_reset();
        end else begin
            for (int d = 0; d < NDUT; d++)
                for (int ch = 0; ch < NCH; ch++)
                    chan_step(d, ch, en[ch], tp[ch], clr, tick);
            m_cnt = tick ? 0 : m_cnt + 1;
        end
        e = '0;
        e.cnt  = 4'(m_cnt);
        e.tick = (m_cnt == FL - 1);
        for (int d = 0; d < NDUT; d++)
            for (int ch = 0; ch < NCH; ch++) begin
                e.trig[d][ch]          = (m_left[d][ch] > 0);
                e.pend[d][ch*3 +: 3]   = 3'(m_pend[d][ch]);
                e.ovf[d][ch]           = m_ovf[d][ch];
            end
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic rn, input logic [NCH-1:0] en, input logic [NCH-1:0] tp, input logic clr);
        @(negedge clk);
        reset_n       = rn;
        ch_en         = en;
        trigger_pulse = tp;
        ovf_clr       = clr;
        model_step(rn, en, tp, clr);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b1, '1, '0, 1'b0);
    endtask

    task automatic wait_phase(input int k);
        for (int i = 0; i < 2 * FL && m_cnt != k; i++) idle(1);
    endtask

    task automatic clear_all();
        cycle(1'b1, '0, '0, 1'b1);
    endtask

    function automatic exp_t sample();
        exp_t a;
        a = '0;
        a.cnt     = cnt_a;
        a.tick    = tick_a;
        a.trig[0] = trig_a;
        a.trig[1] = trig_b;
        a.trig[2] = trig_c;
        a.pend[0] = pend_a;
        a.pend[2] = pend_c;
        for (int ch = 0; ch < NCH; ch++) a.pend[1][ch*3 +: 3] = {1'b0, pend_b[ch*2 +: 2]};
        a.ovf[0] = ovf_a;
        a.ovf[1] = ovf_b;
        a.ovf[2] = ovf_c;
        return a;
    endfunction

    // Monitor: outputs are presented every cycle, so each post-edge sample retires one queued expectation.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = sample();
                check("tx_counter", 0, 32'(a.cnt), 32'(e.cnt));
                check("tx_counter", 1, 32'(cnt_b), 32'(e.cnt));
                check("tx_counter", 2, 32'(cnt_c), 32'(e.cnt));
                check("frame_tick", 0, 32'(a.tick), 32'(e.tick));
                check("frame_tick", 1, 32'(tick_b), 32'(e.tick));
                check("frame_tick", 2, 32'(tick_c), 32'(e.tick));
                for (int d = 0; d < NDUT; d++) begin
                    check("is_trigger",  d, 32'(a.trig[d]), 32'(e.trig[d]));
                    check("pending_cnt", d, 32'(a.pend[d]), 32'(e.pend[d]));
                    check("overflow",    d, 32'(a.ovf[d]),  32'(e.ovf[d]));
                end
            end
        end
    end

    task automatic async_reset_check();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_cnt",  0, 32'(cnt_a), 32'd0);
        check("async_rst_trig", 0, 32'({trig_a, trig_b, trig_c}), 32'd0);
        check("async_rst_pend", 0, 32'({pend_a, pend_b, pend_c}), 32'd0);
        check("async_rst_ovf",  0, 32'({ovf_a, ovf_b, ovf_c}), 32'd0);
    endtask

    initial begin
        logic             rn;
        logic [NCH-1:0]   en, tp;
        logic             clr;

        reset_n       = 1'b0;
        ch_en         = '0;
        trigger_pulse = '0;
        ovf_clr       = 1'b0;
        model_reset();

        repeat (3) cycle(1'b0, '0, '0, 1'b0);
        idle(5);

        // Single trigger mid-frame on ch0.
        wait_phase(3);
        cycle(1'b1, '1, 4'b0001, 1'b0);
        idle(40);
        clear_all();

        // Trigger on the frame_tick cycle on ch1.
        wait_phase(9);
        cycle(1'b1, '1, 4'b0010, 1'b0);
        idle(45);
        clear_all();

        // Two triggers in one frame on ch0: burst chaining with and without the gap frame.
        wait_phase(2);
        cycle(1'b1, '1, 4'b0001, 1'b0);
        idle(2);
        cycle(1'b1, '1, 4'b0001, 1'b0);
        idle(90);
        clear_all();

        // Saturate ch2 while active, then clear overflow.
        wait_phase(0);
        cycle(1'b1, '1, 4'b0100, 1'b0);
        idle(11);
        repeat (5) cycle(1'b1, '1, 4'b0100, 1'b0);
        idle(2);
        cycle(1'b1, '1, '0, 1'b1);
        idle(120);
        clear_all();

        // Drop ch_en[3] mid-window with a queued request.
        wait_phase(0);
        cycle(1'b1, '1, 4'b1000, 1'b0);
        idle(14);
        cycle(1'b1, '1, 4'b1000, 1'b0);
        idle(2);
        cycle(1'b1, 4'b0111, '0, 1'b0);
        idle(25);

        // Asynchronous reset in the middle of an active window.
        wait_phase(0);
        cycle(1'b1, '1, 4'b0001, 1'b0);
        idle(14);
        async_reset_check();
        repeat (2) cycle(1'b0, '1, '0, 1'b0);
        idle(15);

        // Randomised traffic.
        for (int i = 0; i < 4000; i++) begin
            rn  = ($urandom_range(0, 999) >= 3);
            clr = ($urandom_range(0, 99) < 4);
            for (int ch = 0; ch < NCH; ch++) begin
                en[ch] = ($urandom_range(0, 99) >= 3);
                tp[ch] = ($urandom_range(0, 99) < ((i % 800 < 400) ? 8 : 30));
            end
            cycle(rn, en, tp, clr);
        end
        idle(3);

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d queued expectations, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
